cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 register file and exception-commit controller for the 5-stage MIPS32 pipeline.
- It is the responder for the CP0 read/write and exception fields carried down the ID/EX pipeline.
- Sits at the MEM/WB commit point. Accepts mtc0 writes and syscall/eret/interrupt events, updates Status/Cause/EPC/EBase/Count/Compare, and drives flush plus redirect PC.
- Exports the architectural CP0 registers back to ID for mfc0 and the exception path.

Parameters:
- EBASE_RESET, 32'h8000_0000, reset value of EBase
- EXC_OFFSET, 12'h180, general exception vector offset from EBase

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- raddr  in  5  CP0 read address (mfc0)
- rdata  out  32  CP0 read data, combinational from current register state
- we  in  1  CP0 write enable (mtc0 committing)
- waddr  in  5  CP0 write address
- wdata  in  32  CP0 write data
- inst_valid  in  1  a real (non-bubble) instruction is committing this cycle
- exc_syscall  in  1  committing instruction is syscall
- exc_eret  in  1  committing instruction is eret
- is_ds  in  1  committing instruction is in a branch/jump delay slot
- exc_pc  in  32  PC of committing instruction
- hw_int  in  6  external interrupt lines, level-sensitive
- ebase, status, cause, epc  out  32 each  current register values
- flush  out  1  squash IF..MEM and redirect this cycle
- exc_target  out  32  redirect PC, valid when flush=1
- timer_int  out  1  timer interrupt pending

Behaviour:
- All state registers update on posedge clk. The same-cycle commit decode (flush, exc_target) is combinational.
- Register map:
  - 9 Count
  - 11 Compare
  - 12 Status
  - 13 Cause
  - 14 EPC
  - 15 EBase
  - Any other address reads 0; writes to it are ignored.
- Reset values (rst=1 at edge): Status=32'h1000_0000, Cause=0, EPC=0, Count=0, Compare=0, EBase=EBASE_RESET, timer pending=0. Combinational outputs then follow: flush=0 unless a commit event is presented.
- Write masks:
  - Status: writable bits [15:8] IM, [1] EXL, [0] IE.
  - Cause: writable bits [9:8] (software interrupts) only.
  - EBase: writable bits [29:12]; [31:30]=2'b10 and [11:0]=0 are fixed.
  - EPC, Count, Compare: all bits writable.
- Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF to 0. An mtc0 to Count wins over the increment.
- Timer pending:
  - Set when Count==Compare (pre-increment value) and Compare!=0.
  - Cleared by any mtc0 to Compare. A Compare write and a match in the same cycle leave pending clear.
  - timer_int = pending.
- Cause.IP[15:10] is loaded every cycle with {hw_int[5]|pending, hw_int[4:0]}.
- Interrupt request: int_req = inst_valid & Status.IE & ~Status.EXL & |(Status[15:8] & Cause[15:8]).
- Commit priority: interrupt > syscall > eret > mtc0. Syscall, eret and mtc0 are qualified by inst_valid.
- Interrupt or syscall (exception entry):
  - flush=1, exc_target={ebase[31:12], EXC_OFFSET}.
  - Next edge: Status.EXL<=1; Cause.ExcCode[6:2]<=0 (interrupt) or 8 (syscall); Cause.BD[31]<=is_ds; EPC<=is_ds ? exc_pc-4 : exc_pc.
  - The committing instruction's mtc0 is discarded.
  - If EXL is already 1, syscall still redirects and updates ExcCode, but EPC and BD are not changed.
- Eret: flush=1, exc_target=epc (current value); next edge Status.EXL<=0. A simultaneous mtc0 is discarded.
- mtc0 alone: masked write at the edge, no flush. rdata reflects the new value from the following cycle. mfc0-after-mtc0 hazards are handled by the hazard unit; this block has no bypass.
- Bubble commit (inst_valid=0): no exception, no write, no flush. Count, timer and IP sampling continue.
- rst asserted mid-operation overrides every commit event in that cycle.

Decomposition:
- Shared package cp0_pkg holds:
  - CP0 address constants (CP0_COUNT..CP0_EBASE)
  - ExcCode constants (EXC_INT=5'd0, EXC_SYS=5'd8)
  - Status/Cause bit-index constants and write masks
- Sub-module cp0_timer (Count/Compare/pending) is natural. The register file and commit logic stay in cp0_unit.

Test Plan:
- Reset: assert rst 1 cycle -> status=32'h1000_0000, ebase=32'h8000_0000, cause=epc=0, flush=0, Count reads 1 in the first cycle after reset.
- mtc0 Status with wdata=32'hFFFF_FFFF -> status reads 32'h1000_FF03; mtc0 EBase with 32'hFFFF_FFFF -> 32'hBFFF_F000.
- Syscall at exc_pc=32'h8000_0100, is_ds=0 -> flush=1, exc_target=32'h8000_0180; next cycle EPC=32'h8000_0100, ExcCode=8, EXL=1, BD=0. Repeat with is_ds=1 -> EPC=32'h8000_00FC, BD=1.
- Eret with EPC=32'h8000_0104 -> flush=1, exc_target=32'h8000_0104; next cycle EXL=0. Eret plus we to EPC in the same cycle -> EPC unchanged.
- Timer: Compare=10, Status=32'h1000_8001 -> pending sets once Count reaches 10; the next valid commit flushes with ExcCode=0. mtc0 Compare clears timer_int. With EXL=1, no interrupt is taken.
- hw_int[0]=1 with IM2 enabled and inst_valid=0 -> no flush; on the first inst_valid=1 cycle -> flush, ExcCode=0. A simultaneous syscall loses: ExcCode=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 register addresses, exception codes, Status/Cause field positions and write masks.
// Latency: none (constants and a pure helper function).
// Backpressure: none.
package cp0_pkg;

  // Register addresses decoded by mtc0/mfc0
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_EBASE   = 5'd15;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  // Status fields
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;

  // Cause fields
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IPHW_LO = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Reset value and software-writable bits
  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;
  localparam logic [31:0] EBASE_FIXED  = 32'h8000_0000;

  // Merge new data into old only where mask bits are set
  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky timer-pending flag.
// Latency: Count and pending update on the edge; writes land one cycle later.
// Backpressure: none; a write to Count overrides the free-running increment.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  // Free-running counter, wraps naturally; software write wins
  always_ff @(posedge clk) begin
    if (rst)           count <= 32'd0;
    else if (count_we) count <= wdata;
    else               count <= count + 32'd1;
  end

  // Compare holds its value until rewritten
  always_ff @(posedge clk) begin
    if (rst)             compare <= 32'd0;
    else if (compare_we) compare <= wdata;
  end

  // Pending is sticky; a Compare write acknowledges it and beats a same-cycle match
  always_ff @(posedge clk) begin
    if (rst)                                        pending <= 1'b0;
    else if (compare_we)                            pending <= 1'b0;
    else if ((count == compare) && (compare != 0))  pending <= 1'b1;
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file and commit-point exception controller (mtc0, syscall, eret, interrupts).
// Latency: flush/exc_target combinational in the commit cycle; register updates on the next edge.
// Backpressure: none; every commit cycle is resolved in place, interrupt > syscall > eret > mtc0.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000,
  parameter logic [11:0] EXC_OFFSET  = 12'h180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        inst_valid,
  input  logic        exc_syscall,
  input  logic        exc_eret,
  input  logic        is_ds,
  input  logic [31:0] exc_pc,
  input  logic [5:0]  hw_int,
  output logic [31:0] ebase,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        flush,
  output logic [31:0] exc_target,
  output logic        timer_int
);

  logic [31:0] status_q, cause_q, epc_q, ebase_q;
  logic [31:0] status_d, cause_d, epc_d, ebase_d;
  logic [31:0] count, compare;
  logic        pending;
  logic        int_req, sys_go, exc_go, eret_go, wr_go;

  assign int_req = inst_valid & status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                   (|(status_q[STATUS_IM_HI:STATUS_IM_LO] & cause_q[CAUSE_IP_HI:CAUSE_IP_LO]));
  assign sys_go  = inst_valid & exc_syscall;
  assign exc_go  = int_req | sys_go;
  assign eret_go = inst_valid & exc_eret & ~exc_go;
  assign wr_go   = inst_valid & we & ~exc_go & ~eret_go;

  assign flush      = exc_go | eret_go;
  assign exc_target = exc_go ? {ebase_q[31:12], EXC_OFFSET} : epc_q;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_go && (waddr == CP0_COUNT)),
    .compare_we (wr_go && (waddr == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .pending    (pending)
  );

  // Next-state for the architectural registers, resolved by commit priority
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    ebase_d  = ebase_q;
    if (exc_go) begin
      status_d[STATUS_EXL] = 1'b1;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = int_req ? EXC_INT : EXC_SYS;
      // Nested exception keeps the original return point
      if (!status_q[STATUS_EXL]) begin
        cause_d[CAUSE_BD] = is_ds;
        epc_d = is_ds ? (exc_pc - 32'd4) : exc_pc;
      end
    end else if (eret_go) begin
      status_d[STATUS_EXL] = 1'b0;
    end else if (wr_go) begin
      case (waddr)
        CP0_STATUS: status_d = masked_write(status_q, wdata, STATUS_WMASK);
        CP0_CAUSE:  cause_d  = masked_write(cause_q, wdata, CAUSE_WMASK);
        CP0_EPC:    epc_d    = wdata;
        CP0_EBASE:  ebase_d  = EBASE_FIXED | (wdata & EBASE_WMASK);
        default:    ;
      endcase
    end
    // Hardware interrupt lines are resampled every cycle; timer shares IP7
    cause_d[CAUSE_IP_HI:CAUSE_IPHW_LO] = {hw_int[5] | pending, hw_int[4:0]};
  end

  // Register the architectural state
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
      ebase_q  <= EBASE_RESET;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      ebase_q  <= ebase_d;
    end
  end

  // mfc0 read port, no bypass of same-cycle writes
  always_comb begin
    rdata = 32'd0;
    case (raddr)
      CP0_COUNT:   rdata = count;
      CP0_COMPARE: rdata = compare;
      CP0_STATUS:  rdata = status_q;
      CP0_CAUSE:   rdata = cause_q;
      CP0_EPC:     rdata = epc_q;
      CP0_EBASE:   rdata = ebase_q;
      default:     rdata = 32'd0;
    endcase
  end

  assign status    = status_q;
  assign cause     = cause_q;
  assign epc       = epc_q;
  assign ebase     = ebase_q;
  assign timer_int = pending;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 1-2ns after posedge.
// Backpressure: none.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        inst_valid, exc_syscall, exc_eret, is_ds;
  logic [31:0] exc_pc;
  logic [5:0]  hw_int;
  logic [31:0] ebase, status, cause, epc, exc_target;
  logic        flush, timer_int;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk         (clk),
    .rst         (rst),
    .raddr       (raddr),
    .rdata       (rdata),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .inst_valid  (inst_valid),
    .exc_syscall (exc_syscall),
    .exc_eret    (exc_eret),
    .is_ds       (is_ds),
    .exc_pc      (exc_pc),
    .hw_int      (hw_int),
    .ebase       (ebase),
    .status      (status),
    .cause       (cause),
    .epc         (epc),
    .flush       (flush),
    .exc_target  (exc_target),
    .timer_int   (timer_int)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    inst_valid = 1'b0; exc_syscall = 1'b0; exc_eret = 1'b0;
    is_ds = 1'b0; exc_pc = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d; inst_valid = 1'b1;
    tick();
    idle();
  endtask

  // Present a syscall/eret commit, optionally with a competing mtc0, check flush/target
  task automatic commit_evt(input string tag, input logic sys, input logic ert,
                            input logic [31:0] pc, input logic ds,
                            input logic [31:0] exp_target);
    inst_valid = 1'b1; exc_syscall = sys; exc_eret = ert;
    exc_pc = pc; is_ds = ds;
    we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    #1;
    chk({tag, "_flush"}, {31'd0, flush}, 32'd1);
    chk({tag, "_target"}, exc_target, exp_target);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1; hw_int = 6'd0; raddr = 5'd9;
    repeat (2) tick();
    chk("rst_status", status, 32'h1000_0000);
    chk("rst_ebase", ebase, 32'h8000_0000);
    chk("rst_cause", cause, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_count0", rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("count_first", rdata, 32'd1);

    // Masked writes
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("status_mask", status, 32'h1000_FF03);
    raddr = 5'd12; #0;
    chk("rd_status", rdata, 32'h1000_FF03);
    mtc0(5'd12, 32'h0000_0000);
    chk("status_clr", status, 32'h1000_0000);
    mtc0(5'd15, 32'hFFFF_FFFF);
    chk("ebase_mask", ebase, 32'hBFFF_F000);
    mtc0(5'd15, 32'h0000_0000);
    chk("ebase_clr", ebase, 32'h8000_0000);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("cause_mask", cause, 32'h0000_0300);
    mtc0(5'd13, 32'h0000_0000);
    mtc0(5'd3, 32'h1234_5678);
    raddr = 5'd3; #0;
    chk("rd_unmapped", rdata, 32'd0);

    // Syscall, not in delay slot; competing EPC write is discarded
    commit_evt("sys0", 1'b1, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0180);
    chk("sys0_epc", epc, 32'h8000_0100);
    chk("sys0_code", {27'd0, cause[6:2]}, 32'd8);
    chk("sys0_exl", {31'd0, status[1]}, 32'd1);
    chk("sys0_bd", {31'd0, cause[31]}, 32'd0);

    // Eret back, then syscall in a delay slot
    commit_evt("eret0", 1'b0, 1'b1, 32'h8000_0180, 1'b0, 32'h8000_0100);
    chk("eret0_exl", {31'd0, status[1]}, 32'd0);
    commit_evt("sys1", 1'b1, 1'b0, 32'h8000_0100, 1'b1, 32'h8000_0180);
    chk("sys1_epc", epc, 32'h8000_00FC);
    chk("sys1_bd", {31'd0, cause[31]}, 32'd1);

    // Nested syscall with EXL=1 leaves EPC/BD alone
    commit_evt("sys2", 1'b1, 1'b0, 32'h8000_0200, 1'b0, 32'h8000_0180);
    chk("sys2_epc", epc, 32'h8000_00FC);
    chk("sys2_bd", {31'd0, cause[31]}, 32'd1);

    // Eret with a same-cycle EPC write: write lost
    mtc0(5'd14, 32'h8000_0104);
    commit_evt("eret1", 1'b0, 1'b1, 32'h8000_0300, 1'b0, 32'h8000_0104);
    chk("eret1_exl", {31'd0, status[1]}, 32'd0);
    chk("eret1_epc", epc, 32'h8000_0104);

    // Timer interrupt
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    chk("tmr_status", status, 32'h1000_8001);
    raddr = 5'd9;
    for (int i = 0; i < 50 && !timer_int; i++) tick();
    chk("tmr_pend", {31'd0, timer_int}, 32'd1);
    chk("tmr_count", rdata, 32'd11);
    tick();
    chk("tmr_ip7", {31'd0, cause[15]}, 32'd1);
    inst_valid = 1'b1; exc_pc = 32'h8000_0300;
    #1;
    chk("tmr_flush", {31'd0, flush}, 32'd1);
    chk("tmr_target", exc_target, 32'h8000_0180);
    tick();
    idle();
    chk("tmr_code", {27'd0, cause[6:2]}, 32'd0);
    chk("tmr_epc", epc, 32'h8000_0300);
    chk("tmr_exl", {31'd0, status[1]}, 32'd1);
    inst_valid = 1'b1;
    #1;
    chk("tmr_exl_block", {31'd0, flush}, 32'd0);
    idle();
    mtc0(5'd11, 32'd0);
    chk("tmr_clr", {31'd0, timer_int}, 32'd0);
    tick();
    chk("tmr_ip7_clr", {31'd0, cause[15]}, 32'd0);

    // Re-arm: IM2 + IE, syscall then eret so ExcCode starts at 8
    mtc0(5'd12, 32'h0000_0401);
    chk("hw_status", status, 32'h1000_0401);
    commit_evt("sys3", 1'b1, 1'b0, 32'h8000_0400, 1'b0, 32'h8000_0180);
    chk("sys3_code", {27'd0, cause[6:2]}, 32'd8);
    commit_evt("eret2", 1'b0, 1'b1, 32'h8000_0180, 1'b0, 32'h8000_0400);

    // Hardware interrupt waits for a real instruction, beats syscall
    hw_int = 6'b000001;
    tick();
    chk("hw_ip2", {31'd0, cause[10]}, 32'd1);
    chk("hw_bubble", {31'd0, flush}, 32'd0);
    commit_evt("hw_int", 1'b1, 1'b0, 32'h8000_0500, 1'b0, 32'h8000_0180);
    chk("hw_code", {27'd0, cause[6:2]}, 32'd0);
    chk("hw_epc", epc, 32'h8000_0500);

    // Reset overrides a commit in the same cycle
    hw_int = 6'd0;
    rst = 1'b1; inst_valid = 1'b1; exc_syscall = 1'b1; exc_pc = 32'h8000_0600;
    tick();
    rst = 1'b0;
    idle();
    chk("mid_rst_status", status, 32'h1000_0000);
    chk("mid_rst_epc", epc, 32'd0);
    chk("mid_rst_cause", cause, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
